seg_display_scheduler: RTL

Time-shares the four-digit seven-segment display between up to `N_SRC` 16-bit debug sources (PC, instruction word, ALU result, register probe, …). It selects one source at a time, skips sources that are not valid, and rotates pages automatically on a dwell timer or manually on a button pulse. It supports freezing the shown value. Its `displayed_number` output drives the display multiplexer's 16-bit input directly.

---
 rtl/seg_display_scheduler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
//
// Time-shares a four-digit seven-segment display between up to N_SRC 16-bit
// debug sources. One source is shown at a time. Sources whose valid bit is low
// are skipped. Pages rotate on a dwell timer (auto mode) or on a button pulse,
// and the shown value can be frozen.
//
// Parameters
//   N_SRC        : number of sources, 2..16
//   DWELL_CYCLES : clocks per page in auto mode, >= 2
//   PW           : page index width (derived)
//
// Ports
//   clk              in  : system clock, all logic on the rising edge
//   rst              in  : synchronous active-high reset
//   src_data         in  : source i occupies bits [16*i +: 16]
//   src_valid        in  : bit i = source i present/selectable (level)
//   btn_next         in  : single-cycle advance pulse (debounced)
//   mode_auto        in  : 1 = timed rotation enabled (level)
//   freeze           in  : holds shown value and blocks advances (level)
//   displayed_number out : registered value for the display multiplexer
//   page             out : index of the current source
//   page_change      out : one-cycle pulse on the first cycle of a new page
//   active           out : 1 while a page is being shown
// -----------------------------------------------------------------------------
module seg_display_scheduler #(
    parameter int N_SRC        = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int PW           = $clog2(N_SRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16*N_SRC-1:0]  src_data,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic                 btn_next,
    input  logic                 mode_auto,
    input  logic                 freeze,
    output logic [15:0]          displayed_number,
    output logic [PW-1:0]        page,
    output logic                 page_change,
    output logic                 active
);

    // Search counter must reach N_SRC, dwell counter must reach DWELL_CYCLES-1.
    localparam int CW = $clog2(N_SRC + 1);
    localparam int DW = $clog2(DWELL_CYCLES);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_SEEK  = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [PW-1:0] LAST_IDX   = PW'(N_SRC - 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(N_SRC - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    // Modulo-N_SRC increment; explicit wrap so non-power-of-2 counts work.
    function automatic logic [PW-1:0] idx_inc(input logic [PW-1:0] idx);
        logic [PW-1:0] nxt;
        if (idx == LAST_IDX) begin
            nxt = '0;
        end else begin
            nxt = idx + PW'(1);
        end
        return nxt;
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [PW-1:0] cand_r;
    logic [PW-1:0] cand_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [DW-1:0] dwell_r;
    logic [DW-1:0] dwell_s;
    logic [PW-1:0] page_s;
    logic [15:0]   disp_s;
    logic          page_change_s;
    logic          active_s;
    logic          advance_s;
    logic [15:0]   src_word_s [N_SRC];

    // Split the flat source bus into one 16-bit word per source.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_word_s[i] = src_data[16*i +: 16];
        end
    end

    // Advance request: button, or dwell expiry in auto mode (never counted twice).
    always_comb begin
        advance_s = btn_next | (mode_auto & (dwell_r == DWELL_LAST));
    end

    // Next-state and next-output computation for the page scheduler.
    always_comb begin
        state_s       = state_r;
        cand_s        = cand_r;
        cnt_s         = cnt_r;
        dwell_s       = dwell_r;
        page_s        = page;
        disp_s        = displayed_number;
        page_change_s = 1'b0;

        case (state_r)
            ST_EMPTY: begin
                disp_s = 16'h0000;
                if (|src_valid) begin
                    // Inclusive search: the current page may still be valid.
                    state_s = ST_SEEK;
                    cand_s  = page;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_EMPTY;
                end
            end

            ST_SEEK: begin
                if (src_valid[cand_r]) begin
                    state_s       = ST_SHOW;
                    page_s        = cand_r;
                    page_change_s = 1'b1;
                    dwell_s       = '0;
                end else begin
                    cand_s = idx_inc(cand_r);
                    cnt_s  = cnt_r + CW'(1);
                    if (cnt_r == LAST_CNT) begin
                        // Every candidate missed: blank the display.
                        state_s = ST_EMPTY;
                        disp_s  = 16'h0000;
                    end else begin
                        state_s = ST_SEEK;
                    end
                end
            end

            ST_SHOW: begin
                if (!freeze) begin
                    disp_s = src_word_s[page];
                end else begin
                    disp_s = displayed_number;
                end

                if (!src_valid[page]) begin
                    // Losing the source wins over freeze.
                    state_s = ST_SEEK;
                    cand_s  = idx_inc(page);
                    cnt_s   = '0;
                end else if (!freeze && advance_s) begin
                    state_s = ST_SEEK;
                    cand_s  = idx_inc(page);
                    cnt_s   = '0;
                end else if (mode_auto && !freeze) begin
                    dwell_s = dwell_r + DW'(1);
                end else begin
                    // Dwell holds; it is deliberately not cleared on mode change.
                    dwell_s = dwell_r;
                end
            end

            default: begin
                state_s = ST_EMPTY;
                cand_s  = '0;
                cnt_s   = '0;
                disp_s  = 16'h0000;
            end
        endcase

        active_s = (state_s == ST_SHOW);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_EMPTY;
            cand_r           <= '0;
            cnt_r            <= '0;
            dwell_r          <= '0;
            page             <= '0;
            displayed_number <= 16'h0000;
            page_change      <= 1'b0;
            active           <= 1'b0;
        end else begin
            state_r          <= state_s;
            cand_r           <= cand_s;
            cnt_r            <= cnt_s;
            dwell_r          <= dwell_s;
            page             <= page_s;
            displayed_number <= disp_s;
            page_change      <= page_change_s;
            active           <= active_s;
        end
    end

endmodule
